// File: rtl/ccg_resp_misr.sv
// Response-compaction MISR for CCGRCG benchmark circuits: folds N_VEC response vectors into a signature and compares it to a golden value.
// Optional build macro CCG_RESP_MASK_EN adds an f_mask input that zeroes don't-care bits before compaction.
module ccg_resp_misr #(
    parameter int             W     = 19,
    parameter int             N_VEC = 256,
    parameter logic [W-1:0]   POLY  = 19'h00027,
    parameter logic [W-1:0]   SEED  = 19'h00000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  golden,
    input  logic [W-1:0]  f_in,
`ifdef CCG_RESP_MASK_EN
    input  logic [W-1:0]  f_mask,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  sig,
    output logic          pass,
    output logic [15:0]   vec_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [15:0] LAST_CNT = 16'(N_VEC - 1);

    state_t          state;
    logic [W-1:0]    golden_q;
    logic [W-1:0]    term;
    logic [W-1:0]    sig_next;
    logic            accept;
    logic            last_vec;

    // One MISR clock: shift left, fold the MSB back through the feedback taps, inject the response.
    function automatic logic [W-1:0] misr_step(input logic [W-1:0] s, input logic [W-1:0] d);
        return {s[W-2:0], 1'b0} ^ (s[W-1] ? POLY : '0) ^ d;
    endfunction

    always_comb begin
`ifdef CCG_RESP_MASK_EN
        term = f_in & ~f_mask;
`else
        term = f_in;
`endif
        sig_next = misr_step(sig, term);
        accept   = in_valid & in_ready;
        last_vec = (vec_cnt == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sig      <= SEED;
            vec_cnt  <= '0;
            golden_q <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_RUN;
                        sig      <= SEED;
                        vec_cnt  <= '0;
                        golden_q <= golden;
                        pass     <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        sig     <= sig_next;
                        vec_cnt <= vec_cnt + 16'd1;
                        // The compare uses the post-update signature so pass is valid together with done.
                        if (last_vec) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= (sig_next == golden_q);
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccg_resp_misr.sv
// Directed bench for ccg_resp_misr: several parameterisations share clock, reset, golden and f_in.
module tb_ccg_resp_misr;

    localparam int W = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  golden = '0;
    logic [W-1:0]  f_in = '0;
`ifdef CCG_RESP_MASK_EN
    logic [W-1:0]  f_mask = '0;
`endif

    logic start_d = 0, start_2 = 0, start_1 = 0, start_m = 0;
    logic valid_d = 0, valid_2 = 0, valid_1 = 0, valid_m = 0;

    logic          rdy_d, busy_d, done_d, pass_d;
    logic [W-1:0]  sig_d;
    logic [15:0]   cnt_d;
    logic          rdy_2, busy_2, done_2, pass_2;
    logic [W-1:0]  sig_2;
    logic [15:0]   cnt_2;
    logic          rdy_1, busy_1, done_1, pass_1;
    logic [W-1:0]  sig_1;
    logic [15:0]   cnt_1;
    logic          rdy_m, busy_m, done_m, pass_m;
    logic [W-1:0]  sig_m;
    logic [15:0]   cnt_m;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ccg_resp_misr u_def (
        .clk(clk), .rst(rst), .start(start_d), .golden(golden), .f_in(f_in),
`ifdef CCG_RESP_MASK_EN
        .f_mask(f_mask),
`endif
        .in_valid(valid_d), .in_ready(rdy_d), .busy(busy_d), .done(done_d),
        .sig(sig_d), .pass(pass_d), .vec_cnt(cnt_d)
    );

    ccg_resp_misr #(.N_VEC(2), .SEED(19'h00000)) u_n2 (
        .clk(clk), .rst(rst), .start(start_2), .golden(golden), .f_in(f_in),
`ifdef CCG_RESP_MASK_EN
        .f_mask(f_mask),
`endif
        .in_valid(valid_2), .in_ready(rdy_2), .busy(busy_2), .done(done_2),
        .sig(sig_2), .pass(pass_2), .vec_cnt(cnt_2)
    );

    ccg_resp_misr #(.N_VEC(1), .SEED(19'h40000)) u_n1 (
        .clk(clk), .rst(rst), .start(start_1), .golden(golden), .f_in(f_in),
`ifdef CCG_RESP_MASK_EN
        .f_mask(f_mask),
`endif
        .in_valid(valid_1), .in_ready(rdy_1), .busy(busy_1), .done(done_1),
        .sig(sig_1), .pass(pass_1), .vec_cnt(cnt_1)
    );

    ccg_resp_misr #(.N_VEC(1), .SEED(19'h00000)) u_m (
        .clk(clk), .rst(rst), .start(start_m), .golden(golden), .f_in(f_in),
`ifdef CCG_RESP_MASK_EN
        .f_mask(f_mask),
`endif
        .in_valid(valid_m), .in_ready(rdy_m), .busy(busy_m), .done(done_m),
        .sig(sig_m), .pass(pass_m), .vec_cnt(cnt_m)
    );

    // Reference MISR step written from the defining equation with POLY = 19'h00027.
    function automatic logic [W-1:0] ref_step(input logic [W-1:0] s, input logic [W-1:0] d);
        logic [W-1:0] r;
        r = {s[W-2:0], 1'b0};
        if (s[W-1]) r = r ^ 19'h00027;
        return r ^ d;
    endfunction

    function automatic logic [W-1:0] vec(input int n);
        logic [31:0] v;
        v = (n * 32'h0001357B + 32'h5A5) ^ (n << 7);
        return v[W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [W-1:0] exp_sig;
    logic [W-1:0] exp_full;
    int acc;
    int cyc;

    initial begin
        // Reset, then in_valid without start must not consume anything
        rst = 1'b1;
        tick();
        tick();
        check("rst_sig", sig_d, 0);
        check("rst_cnt", cnt_d, 0);
        check("rst_rdy", rdy_d, 0);
        check("rst_busy", busy_d, 0);
        check("rst_done", done_d, 0);
        check("rst_pass", pass_d, 0);
        rst = 1'b0;
        valid_d = 1'b1;
        f_in = 19'h12345;
        repeat (5) tick();
        check("idle_sig", sig_d, 0);
        check("idle_cnt", cnt_d, 0);
        check("idle_rdy", rdy_d, 0);
        check("idle_busy", busy_d, 0);
        check("idle_done", done_d, 0);
        valid_d = 1'b0;

        // N_VEC=2, two back-to-back 1s: 0 -> 1 -> 3
        golden = 19'h00003;
        start_2 = 1'b1;
        tick();
        start_2 = 1'b0;
        check("n2_busy", busy_2, 1);
        check("n2_rdy", rdy_2, 1);
        check("n2_sig0", sig_2, 0);
        f_in = 19'h00001;
        valid_2 = 1'b1;
        tick();
        check("n2_sig1", sig_2, 19'h00001);
        check("n2_cnt1", cnt_2, 1);
        check("n2_done1", done_2, 0);
        tick();
        check("n2_sig2", sig_2, 19'h00003);
        check("n2_done2", done_2, 1);
        check("n2_cnt2", cnt_2, 2);
        check("n2_pass", pass_2, 1);
        check("n2_rdy_done", rdy_2, 0);
        check("n2_busy_done", busy_2, 0);
        tick();
        check("n2_hold_sig", sig_2, 19'h00003);
        check("n2_hold_cnt", cnt_2, 2);
        valid_2 = 1'b0;

        // Restart from DONE with a new golden; later golden edits and start in RUN are ignored
        golden = 19'h00005;
        start_2 = 1'b1;
        tick();
        start_2 = 1'b0;
        check("rs_busy", busy_2, 1);
        check("rs_done", done_2, 0);
        check("rs_sig", sig_2, 0);
        check("rs_pass", pass_2, 0);
        check("rs_cnt", cnt_2, 0);
        golden = 19'h00003;
        f_in = 19'h00001;
        valid_2 = 1'b1;
        tick();
        start_2 = 1'b1;
        tick();
        start_2 = 1'b0;
        valid_2 = 1'b0;
        check("rs_cnt_end", cnt_2, 2);
        check("rs_done_end", done_2, 1);
        check("rs_sig_end", sig_2, 19'h00003);
        check("rs_pass_end", pass_2, 0);

        // N_VEC=1, SEED MSB set, zero input: result is the feedback polynomial
        golden = 19'h00000;
        start_1 = 1'b1;
        tick();
        start_1 = 1'b0;
        check("n1_sig_seed", sig_1, 19'h40000);
        f_in = 19'h00000;
        valid_1 = 1'b1;
        tick();
        valid_1 = 1'b0;
        check("n1_sig", sig_1, 19'h00027);
        check("n1_done", done_1, 1);
        check("n1_pass", pass_1, 0);
        check("n1_cnt", cnt_1, 1);

        // Masked build zeroes don't-care bits; unmasked build compacts all bits
        golden = 19'h00001;
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        f_in = 19'h7FFFF;
`ifdef CCG_RESP_MASK_EN
        f_mask = 19'h7FFFE;
`endif
        valid_m = 1'b1;
        tick();
        valid_m = 1'b0;
`ifdef CCG_RESP_MASK_EN
        f_mask = '0;
        check("mask_sig", sig_m, 19'h00001);
        check("mask_pass", pass_m, 1);
`else
        check("nomask_sig", sig_m, 19'h7FFFF);
        check("nomask_pass", pass_m, 0);
`endif
        check("mask_done", done_m, 1);

        // Default N_VEC=256: stalled run, reset after 100 accepts
        golden = 19'h00000;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        exp_sig = 19'h00000;
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            valid_d = (i % 2 == 0);
            f_in = vec(acc);
            if (valid_d) begin
                exp_sig = ref_step(exp_sig, f_in);
                acc++;
            end
            tick();
        end
        valid_d = 1'b0;
        check("stall_cnt100", cnt_d, 100);
        check("stall_sig100", sig_d, exp_sig);
        check("stall_busy", busy_d, 1);
        rst = 1'b1;
        start_d = 1'b1;
        tick();
        rst = 1'b0;
        start_d = 1'b0;
        check("midrst_busy", busy_d, 0);
        check("midrst_sig", sig_d, 0);
        check("midrst_cnt", cnt_d, 0);
        check("midrst_rdy", rdy_d, 0);

        // Full 256-vector run with 50% in_valid duty
        exp_full = 19'h00000;
        for (int n = 0; n < 256; n++) exp_full = ref_step(exp_full, vec(n));
        golden = exp_full;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        golden = ~exp_full;
        acc = 0;
        cyc = 0;
        while (acc < 256 && cyc < 2000) begin
            valid_d = (cyc % 2 == 0);
            f_in = vec(acc);
            if (valid_d && acc == 255) begin
                check("full_cnt255", cnt_d, 255);
                check("full_notdone", done_d, 0);
            end
            tick();
            if (valid_d) acc++;
            cyc++;
        end
        check("full_accepts", acc, 256);
        check("full_done", done_d, 1);
        check("full_busy", busy_d, 0);
        check("full_cnt", cnt_d, 256);
        check("full_sig", sig_d, exp_full);
        check("full_pass", pass_d, 1);
        valid_d = 1'b1;
        f_in = 19'h0ABCD;
        tick();
        tick();
        valid_d = 1'b0;
        check("done_hold_sig", sig_d, exp_full);
        check("done_hold_cnt", cnt_d, 256);
        check("done_hold_pass", pass_d, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ccg_resp_misr.md
Name: ccg_resp_misr

Overview:
- Downstream response-compaction stage for the generated combinational benchmark circuits (CCGRCG family).
- Consumes the W-bit output vector (f1..fW) of the circuit-under-test, one vector per handshake, and compacts N_VEC vectors into a W-bit MISR signature.
- Compares the final signature against a golden value so that original and balanced AIG netlists can be checked for equivalence in simulation or on FPGA without storing full response traces.

Parameters:
- W, 19, response vector width; equals the circuit's output count.
- N_VEC, 256, vectors compacted per run; legal range 1..65535.
- POLY, 19'h00027, MISR feedback taps. Bit i set means MSB feedback is XORed into sig bit i.
- SEED, 19'h00000, signature value loaded at reset and at each run start.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a run from IDLE or DONE
- golden  in  W  expected signature; sampled in the cycle start is accepted
- f_in  in  W  response vector from the circuit-under-test
- in_valid  in  1  f_in is valid this cycle
- in_ready  out  1  block accepts f_in this cycle
- busy  out  1  high while in RUN
- done  out  1  high while in DONE
- sig  out  W  current signature register
- pass  out  1  valid when done=1; 1 if sig==golden
- vec_cnt  out  16  number of vectors accepted in the current run

Behaviour:
- Reset (rst=1 at a clock edge, from any state, including mid-run):
  - state=IDLE, sig=SEED, vec_cnt=0.
  - in_ready=0, busy=0, done=0, pass=0, golden register=0.
  - A partial run is discarded.
- Accept: a vector is accepted in any cycle where in_valid & in_ready.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=0. start=1 -> RUN; sig<=SEED, vec_cnt<=0, golden register<=golden, pass<=0.
  - RUN: in_ready=1, busy=1. On each accept:
    - sig <= {sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0) ^ f_in
    - vec_cnt <= vec_cnt+1
    - If this accept is vector N_VEC (vec_cnt==N_VEC-1 before the update), go to DONE next cycle.
    - start is ignored in RUN.
    - in_valid=0 stalls the run without limit; sig and vec_cnt hold.
  - DONE: in_ready=0, done=1.
    - pass is registered on entry as (final sig == golden register).
    - sig, vec_cnt and pass hold.
    - start=1 -> RUN with the same reload actions as in IDLE.
- Latency: sig reflects an accepted vector one cycle after the accept edge. done and pass assert the cycle after the final accept.
- Boundaries:
  - in_valid asserted in IDLE or DONE is ignored; no vector is consumed.
  - N_VEC=1: DONE after the first accept.
  - vec_cnt never wraps, because N_VEC ≤ 65535.
  - start and rst asserted together: rst wins.
  - golden changes after start have no effect on the current run.
- All arithmetic is unsigned and modulo 2 (XOR); there is no carry anywhere in the MISR.

Optional Feature:
- Macro: CCG_RESP_MASK_EN.
- Defined:
  - Adds input port f_mask (W bits).
  - The compacted term becomes f_in & ~f_mask, so masked bits contribute 0. This is used for unknown or don't-care outputs.
  - f_mask is sampled together with f_in on each accept.
- Undefined:
  - No f_mask port.
  - All W bits of f_in are compacted unmasked.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then idle: rst for 2 cycles, then in_valid=1 with no start for 5 cycles -> sig=0, vec_cnt=0, in_ready=0, busy=0, done=0.
- N_VEC=2, SEED=0: start, then f_in=19'h00001 twice back-to-back -> sig=19'h00001 after the 1st accept and 19'h00003 after the 2nd; done=1 and vec_cnt=2 the next cycle; pass=1 when golden=19'h00003.
- N_VEC=1, SEED=19'h40000, f_in=0 -> sig=19'h00027 (MSB feedback XORs POLY); pass=0 when golden=0.
- Stall and reset mid-run: default N_VEC=256, in_valid toggling with 50% duty; assert rst after 100 accepts -> next cycle IDLE, sig=SEED, vec_cnt=0. Restart and run 256 vectors -> done after exactly 256 accepts.
- Restart from DONE: start in DONE with a new golden -> RUN with sig=SEED and pass=0. start asserted during RUN -> ignored; vec_cnt is not reset.
- CCG_RESP_MASK_EN build, N_VEC=1, SEED=0: f_in=19'h7FFFF, f_mask=19'h7FFFE -> sig=19'h00001.
